emitter_fifo: RTL and testbench

- Byte FIFO with a Wishbone read-only responder port.
- Occupies the FIFO slot (address bits [31:30] = 2'b11) of the emitter data-bus decoder, which forwards stb, sel[0], rdt[9:0] and ack unchanged.
- The write side is filled by the collector logic with bytes plus an end-of-record flag.
- Firmware on the CPU drains it by word reads and either pops an entry or reads status, selected by sel[0].

---
 rtl/emitter_fifo.sv | 106 ++++++++++
 tb/tb_emitter_fifo.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/emitter_fifo.sv
// rtl/emitter_fifo.sv - byte FIFO with a Wishbone read-only pop/status responder
//
// Purpose: the collector pushes {last, data} bytes; firmware drains them through
// single-cycle-latency Wishbone reads, either popping the head (sel=1) or
// reading status (sel=0).
//
// Ports:
//   i_clk          clock, all logic on the rising edge
//   i_rst          asynchronous active-high reset
//   i_dat[7:0]     write data byte
//   i_last         end-of-record flag stored alongside the byte
//   i_valid        write request (writer holds it until o_ready)
//   o_ready        write accepted when high (= !full)
//   i_wb_fifo_sel  1 = pop read, 0 = status read
//   i_wb_fifo_stb  read strobe
//   o_wb_fifo_rdt  registered read data
//   o_wb_fifo_ack  single-cycle acknowledge
module emitter_fifo #(
  parameter int AW = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_dat,
  input  logic       i_last,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic       i_wb_fifo_sel,
  input  logic       i_wb_fifo_stb,
  output logic [9:0] o_wb_fifo_rdt,
  output logic       o_wb_fifo_ack
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

  logic [8:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ack_q, ack_d;
  logic [9:0]    rdt_q, rdt_d;

  logic full, empty, push, pop, accept;
  logic [7:0] count8;

  assign full    = (count_q == DEPTH_CNT);
  assign empty   = (count_q == '0);
  assign o_ready = !full;
  assign count8  = 8'(count_q);

  // A strobe is only taken when no ack is outstanding, so a held stb yields
  // one ack every other cycle.
  assign accept = i_wb_fifo_stb && !ack_q;
  assign push   = i_valid && !full;
  assign pop    = accept && i_wb_fifo_sel && !empty;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ack_d   = accept;
    rdt_d   = rdt_q;

    if (accept) begin
      if (i_wb_fifo_sel) begin
        // Head is read from pre-push state: a same-cycle push into an
        // empty FIFO is not visible here.
        rdt_d = empty ? 10'd0 : {1'b1, mem_q[rptr_q]};
      end else begin
        rdt_d = {1'b0, full, count8};
      end
    end

    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;

    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ack_q   <= 1'b0;
      rdt_q   <= 10'd0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ack_q   <= ack_d;
      rdt_q   <= rdt_d;
    end
  end

  // Storage needs no reset: stale contents are unreachable once the
  // pointers and count are cleared.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wptr_q] <= {i_last, i_dat};
  end

  assign o_wb_fifo_ack = ack_q;
  assign o_wb_fifo_rdt = rdt_q;

endmodule

// File: tb/tb_emitter_fifo.sv
// tb/tb_emitter_fifo.sv - self-checking bench for emitter_fifo
module tb_emitter_fifo;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic       clk;
  logic       rst;
  logic [7:0] dat;
  logic       last;
  logic       valid;
  logic       ready;
  logic       sel;
  logic       stb;
  logic [9:0] rdt;
  logic       ack;

  emitter_fifo #(.AW(AW)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_dat         (dat),
    .i_last        (last),
    .i_valid       (valid),
    .o_ready       (ready),
    .i_wb_fifo_sel (sel),
    .i_wb_fifo_stb (stb),
    .o_wb_fifo_rdt (rdt),
    .o_wb_fifo_ack (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: FIFO as a queue of {last,data}, plus the bus reply state.
  logic [8:0] mq[$];
  logic       m_ack;
  logic [9:0] m_rdt;

  task automatic model_reset();
    mq.delete();
    m_ack = 1'b0;
    m_rdt = 10'd0;
  endtask

  task automatic model_edge();
    bit acc, full_b, empty_b;
    full_b  = (mq.size() == DEPTH);
    empty_b = (mq.size() == 0);
    acc     = stb && !m_ack;
    if (acc) begin
      if (sel) begin
        if (!empty_b) begin
          m_rdt = {1'b1, mq[0]};
          void'(mq.pop_front());
        end else begin
          m_rdt = 10'd0;
        end
      end else begin
        m_rdt = {1'b0, full_b, 8'(mq.size())};
      end
    end
    m_ack = acc;
    if (valid && !full_b) mq.push_back({last, dat});
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       valid;
    logic [7:0] dat;
    logic       last;
    logic       stb;
    logic       sel;
    logic       exp_ack;
    logic [9:0] exp_rdt;
    logic       exp_ready;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [7:0] d, logic l, logic s, logic sl,
                              logic ea, logic [9:0] er, logic ey);
    vec_t t;
    t.valid = v; t.dat = d; t.last = l; t.stb = s; t.sel = sl;
    t.exp_ack = ea; t.exp_rdt = er; t.exp_ready = ey;
    return t;
  endfunction

  initial begin
    rst = 1'b1; valid = 0; dat = 0; last = 0; stb = 0; sel = 0;
    model_reset();

    //                 v  dat    l  stb sel  ack  rdt      rdy
    tbl.push_back(mk(0, 8'h00, 0, 1, 0,   1, 10'h000, 1)); // status after reset
    tbl.push_back(mk(0, 8'h00, 0, 0, 0,   0, 10'h000, 1));
    tbl.push_back(mk(1, 8'hA5, 0, 0, 0,   0, 10'h000, 1));
    tbl.push_back(mk(1, 8'h3C, 1, 0, 0,   0, 10'h000, 1));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1,   1, 10'h2A5, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0,   0, 10'h2A5, 1)); // rdt holds
    tbl.push_back(mk(0, 8'h00, 0, 1, 1,   1, 10'h33C, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0,   0, 10'h33C, 1));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1,   1, 10'h000, 1)); // pop on empty
    tbl.push_back(mk(0, 8'h00, 0, 1, 0,   0, 10'h000, 1)); // stb held: no ack
    tbl.push_back(mk(0, 8'h00, 0, 1, 0,   1, 10'h000, 1)); // count 0
    tbl.push_back(mk(1, 8'h01, 0, 0, 0,   0, 10'h000, 1));
    tbl.push_back(mk(1, 8'h02, 0, 0, 0,   0, 10'h000, 1));
    tbl.push_back(mk(1, 8'h03, 0, 0, 0,   0, 10'h000, 1));
    tbl.push_back(mk(1, 8'h04, 0, 0, 0,   0, 10'h000, 0)); // now full
    tbl.push_back(mk(1, 8'h05, 0, 0, 0,   0, 10'h000, 0)); // refused
    tbl.push_back(mk(1, 8'h05, 0, 1, 0,   1, 10'h104, 0)); // full, count 4
    tbl.push_back(mk(1, 8'h05, 0, 0, 0,   0, 10'h104, 0));
    tbl.push_back(mk(1, 8'h05, 0, 1, 1,   1, 10'h201, 1)); // pop; push refused at full
    tbl.push_back(mk(1, 8'h05, 0, 0, 0,   0, 10'h201, 0)); // 0x05 accepted, wraps
    tbl.push_back(mk(0, 8'h00, 0, 1, 1,   1, 10'h202, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0,   0, 10'h202, 1));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1,   1, 10'h203, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0,   0, 10'h203, 1));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1,   1, 10'h204, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0,   0, 10'h204, 1));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1,   1, 10'h205, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0,   0, 10'h205, 1));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0,   1, 10'h000, 1));
    tbl.push_back(mk(1, 8'h11, 0, 0, 0,   0, 10'h000, 1));
    tbl.push_back(mk(1, 8'h12, 0, 0, 0,   0, 10'h000, 1));
    tbl.push_back(mk(1, 8'h13, 0, 0, 0,   0, 10'h000, 1));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1,   1, 10'h211, 1)); // stb held 4 cycles
    tbl.push_back(mk(0, 8'h00, 0, 1, 1,   0, 10'h211, 1));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1,   1, 10'h212, 1));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1,   0, 10'h212, 1));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0,   1, 10'h001, 1)); // count 1
    tbl.push_back(mk(0, 8'h00, 0, 0, 0,   0, 10'h001, 1));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1,   1, 10'h213, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0,   0, 10'h213, 1));
    tbl.push_back(mk(1, 8'h77, 1, 1, 1,   1, 10'h000, 1)); // push into empty + pop
    tbl.push_back(mk(0, 8'h00, 0, 0, 0,   0, 10'h000, 1));
    tbl.push_back(mk(1, 8'h88, 0, 0, 0,   0, 10'h000, 1));
    tbl.push_back(mk(1, 8'h99, 0, 1, 1,   1, 10'h377, 1)); // push+pop at count 2
    tbl.push_back(mk(0, 8'h00, 0, 0, 0,   0, 10'h377, 1));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0,   1, 10'h002, 1)); // count stays 2
    tbl.push_back(mk(0, 8'h00, 0, 0, 0,   0, 10'h002, 1));

    @(posedge clk);
    #1;
    check("reset_ack",   32'(ack),   32'd0);
    check("reset_rdt",   32'(rdt),   32'd0);
    check("reset_ready", 32'(ready), 32'd1);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      valid = tbl[i].valid; dat = tbl[i].dat; last = tbl[i].last;
      stb   = tbl[i].stb;   sel = tbl[i].sel;
      step();
      check($sformatf("vec%0d_ack", i),   32'(ack),   32'(tbl[i].exp_ack));
      check($sformatf("vec%0d_rdt", i),   32'(rdt),   32'(tbl[i].exp_rdt));
      check($sformatf("vec%0d_ready", i), 32'(ready), 32'(tbl[i].exp_ready));
    end

    // Asynchronous reset while an ack is being driven.
    valid = 0; stb = 1; sel = 1;
    step();
    check("pre_rst_ack", 32'(ack), 32'd1);
    check("pre_rst_rdt", 32'(rdt), 32'h288);
    stb = 0;
    #3 rst = 1'b1;
    #1;
    check("async_rst_ack",   32'(ack),   32'd0);
    check("async_rst_rdt",   32'(rdt),   32'd0);
    check("async_rst_ready", 32'(ready), 32'd1);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_no_ack", 32'(ack), 32'd0);
    end
    stb = 1; sel = 0;
    step();
    check("post_rst_status_ack", 32'(ack), 32'd1);
    check("post_rst_status_rdt", 32'(rdt), 32'h000);
    stb = 0;
    step();

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      valid = ($urandom_range(0, 9) < 6);
      dat   = 8'($urandom);
      last  = 1'($urandom);
      stb   = 1'($urandom);
      sel   = ($urandom_range(0, 9) < 7);
      step();
      check("rand_ack",   32'(ack),   32'(m_ack));
      check("rand_rdt",   32'(rdt),   32'(m_rdt));
      check("rand_ready", 32'(ready), 32'(mq.size() != DEPTH));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
